// File: rtl/dsp_din_arbiter_if.sv
// rtl/dsp_din_arbiter_if.sv - producer/consumer bus bundle for the DIn round-robin arbiter
interface dsp_din_arbiter_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    localparam int CW = $clog2(CHANNELS);

    logic [CHANNELS-1:0]       InValid;
    logic [CHANNELS*WIDTH-1:0] InData;
    logic [CHANNELS-1:0]       InReady;
    logic                      OutValid;
    logic [WIDTH-1:0]          OutData;
    logic [CW-1:0]             OutChan;
    logic                      OutReady;

    // Drives producers and the consumer ready (bench / surrounding logic).
    modport master (
        output InValid, InData, OutReady,
        input  InReady, OutValid, OutData, OutChan
    );

    // Arbiter side.
    modport slave (
        input  InValid, InData, OutReady,
        output InReady, OutValid, OutData, OutChan
    );
endinterface

// File: rtl/dsp_din_arbiter.sv
// rtl/dsp_din_arbiter.sv - per-channel FIFOs merged round-robin onto one tagged DSP output
module dsp_din_arbiter #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 4
) (
    input  logic          Clk,
    input  logic          nReset,
    dsp_din_arbiter_if.slave bus
);
    localparam int CW = $clog2(CHANNELS);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0]    mem_q    [CHANNELS][DEPTH];
    logic [AW-1:0]       wr_ptr_q [CHANNELS];
    logic [AW-1:0]       rd_ptr_q [CHANNELS];
    logic [AW:0]         count_q  [CHANNELS];
    logic [AW:0]         count_d  [CHANNELS];
    logic                ready_en_q;
    logic [CW-1:0]       rr_ptr_q;
    logic                out_valid_q;
    logic [WIDTH-1:0]    out_data_q;
    logic [CW-1:0]       out_chan_q;

    logic [CHANNELS-1:0] ready;
    logic [CHANNELS-1:0] push;
    logic [CHANNELS-1:0] pop;
    logic                load;
    logic                gnt_found;
    logic [CW-1:0]       gnt_chan;

    // Full check only; ready_en_q keeps InReady low through reset and its release cycle.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            ready[i] = ready_en_q && (count_q[i] != (AW+1)'(DEPTH));
            push[i]  = bus.InValid[i] && ready[i];
        end
    end

    // Round-robin search from rr_ptr+1 with wrap; walking backwards lets the nearest channel win.
    always_comb begin
        gnt_found = 1'b0;
        gnt_chan  = '0;
        for (int k = CHANNELS; k >= 1; k--) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % CHANNELS;
            if (count_q[idx] != '0) begin
                gnt_found = 1'b1;
                gnt_chan  = CW'(idx);
            end
        end
    end

    // Pop the granted FIFO whenever the output register is free to take a word.
    always_comb begin
        load = !out_valid_q || bus.OutReady;
        for (int i = 0; i < CHANNELS; i++) begin
            pop[i]     = load && gnt_found && (gnt_chan == CW'(i));
            count_d[i] = count_q[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
        end
    end

    // FIFO storage is not reset; occupancy is governed entirely by the counts.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= bus.InData[i*WIDTH +: WIDTH];
            end
        end
    end

    // FIFO pointers and counts; reset discards everything buffered.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            ready_en_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            ready_en_q <= 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
                count_q[i] <= count_d[i];
            end
        end
    end

    // Output register: holds under backpressure, otherwise loads the granted word or empties.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            rr_ptr_q    <= CW'(CHANNELS - 1);
        end else if (load) begin
            if (gnt_found) begin
                out_valid_q <= 1'b1;
                out_data_q  <= mem_q[gnt_chan][rd_ptr_q[gnt_chan]];
                out_chan_q  <= gnt_chan;
                rr_ptr_q    <= gnt_chan;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.InReady  = ready;
    assign bus.OutValid = out_valid_q;
    assign bus.OutData  = out_data_q;
    assign bus.OutChan  = out_chan_q;
endmodule

// File: tb/tb_dsp_din_arbiter.sv
// tb/tb_dsp_din_arbiter.sv - directed self-checking bench for dsp_din_arbiter
module tb_dsp_din_arbiter;
    logic Clk;
    logic nReset;
    int   vectors;
    int   miscompares;

    dsp_din_arbiter_if #(.WIDTH(8), .CHANNELS(4)) bus ();

    dsp_din_arbiter #(.WIDTH(8), .CHANNELS(4), .DEPTH(4)) dut (
        .Clk    (Clk),
        .nReset (nReset),
        .bus    (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] word_of(input int ch, input int seq);
        return {ch[1:0], seq[5:0]};
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        step();
        nReset = 1'b1;
        step();
    endtask

    initial begin
        logic [3:0] rdy;
        int         seq_in  [4];
        int         seq_out [4];
        int         exp_chan;
        int         n_acc;
        int         exp_word;

        vectors     = 0;
        miscompares = 0;
        nReset      = 1'b1;
        bus.InValid  = '0;
        bus.InData   = '0;
        bus.OutReady = 1'b1;

        // Reset then idle
        #3 nReset = 1'b0;
        step();
        chk("inready_in_reset", {28'd0, bus.InReady}, 32'h0);
        nReset = 1'b1;
        step();
        chk("rst_outvalid", {31'd0, bus.OutValid}, 32'h0);
        chk("rst_outdata", {24'd0, bus.OutData}, 32'h0);
        chk("rst_outchan", {30'd0, bus.OutChan}, 32'h0);
        chk("rst_inready", {28'd0, bus.InReady}, 32'hF);

        // Channel 2 single word, two-edge latency
        bus.InValid = 4'b0100;
        bus.InData[2*8 +: 8] = 8'hA5;
        step();
        bus.InValid = 4'b0000;
        chk("lat_e0_valid", {31'd0, bus.OutValid}, 32'h0);
        step();
        chk("lat_e1_valid", {31'd0, bus.OutValid}, 32'h1);
        chk("lat_e1_data", {24'd0, bus.OutData}, 32'hA5);
        chk("lat_e1_chan", {30'd0, bus.OutChan}, 32'h2);
        step();
        chk("lat_e2_valid", {31'd0, bus.OutValid}, 32'h0);

        // All channels valid every cycle: strict rotation, in-order data
        do_reset();
        for (int c = 0; c < 4; c++) begin
            seq_in[c]  = 0;
            seq_out[c] = 0;
            bus.InData[c*8 +: 8] = word_of(c, 0);
        end
        bus.InValid = 4'b1111;
        exp_chan = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            rdy = bus.InReady;
            step();
            for (int c = 0; c < 4; c++) begin
                if (rdy[c]) begin
                    seq_in[c]++;
                    bus.InData[c*8 +: 8] = word_of(c, seq_in[c]);
                end
            end
            if (cyc == 0) begin
                chk("rr_first_valid", {31'd0, bus.OutValid}, 32'h0);
            end else begin
                chk("rr_valid", {31'd0, bus.OutValid}, 32'h1);
                chk("rr_chan", {30'd0, bus.OutChan}, 32'(exp_chan));
                chk("rr_data", {24'd0, bus.OutData}, {24'd0, word_of(exp_chan, seq_out[exp_chan])});
                seq_out[exp_chan]++;
                exp_chan = (exp_chan + 1) % 4;
            end
        end
        bus.InValid = 4'b0000;

        // Backpressure: ch1 fills the output register plus its FIFO, then drains in order
        do_reset();
        bus.OutReady = 1'b0;
        bus.InValid  = 4'b0010;
        bus.InData[1*8 +: 8] = 8'h01;
        n_acc = 0;
        for (int cyc = 0; cyc < 20 && n_acc < 5; cyc++) begin
            rdy = bus.InReady;
            step();
            if (rdy[1]) begin
                n_acc++;
                bus.InData[1*8 +: 8] = 8'(n_acc + 1);
            end
        end
        chk("bp_accepted", 32'(n_acc), 32'd5);
        chk("bp_full_ready", {31'd0, bus.InReady[1]}, 32'h0);
        chk("bp_hold_valid", {31'd0, bus.OutValid}, 32'h1);
        chk("bp_hold_data", {24'd0, bus.OutData}, 32'h01);
        chk("bp_hold_chan", {30'd0, bus.OutChan}, 32'h1);
        step();
        step();
        chk("bp_refuse_ready", {31'd0, bus.InReady[1]}, 32'h0);
        chk("bp_refuse_data", {24'd0, bus.OutData}, 32'h01);
        bus.InValid  = 4'b0000;
        bus.OutReady = 1'b1;
        exp_word = 1;
        for (int cyc = 0; cyc < 20 && exp_word <= 5; cyc++) begin
            if (bus.OutValid) begin
                chk("drain_data", {24'd0, bus.OutData}, 32'(exp_word));
                chk("drain_chan", {30'd0, bus.OutChan}, 32'h1);
                exp_word++;
            end
            step();
        end
        chk("drain_count", 32'(exp_word), 32'd6);
        chk("drain_empty", {31'd0, bus.OutValid}, 32'h0);

        // Asynchronous reset mid-burst with three channels buffered
        do_reset();
        bus.OutReady = 1'b0;
        bus.InValid  = 4'b0111;
        bus.InData   = {8'h00, 8'h33, 8'h22, 8'h11};
        step();
        bus.InValid = 4'b0000;
        step();
        chk("mid_loaded_valid", {31'd0, bus.OutValid}, 32'h1);
        chk("mid_loaded_data", {24'd0, bus.OutData}, 32'h11);
        #2 nReset = 1'b0;
        #1;
        chk("async_drop_valid", {31'd0, bus.OutValid}, 32'h0);
        chk("async_drop_ready", {28'd0, bus.InReady}, 32'h0);
        step();
        nReset = 1'b1;
        bus.OutReady = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            step();
            chk("post_rst_valid", {31'd0, bus.OutValid}, 32'h0);
            chk("post_rst_data", {24'd0, bus.OutData}, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
